// File: rtl/asynchronous_fifo_pkg.sv
// Shared pointer type and gray-code helpers for asynchronous_fifo.
// Pointers carry one extra MSB beyond the address so that full and empty can be told apart.
package asynchronous_fifo_pkg;

    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // In gray code a pointer exactly one lap ahead differs only in its two top bits.
    function automatic ptr_t gray_lap_ahead(input ptr_t gray);
        return {~gray[FIFO_ADDR_WIDTH -: 2], gray[FIFO_ADDR_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/asynchronous_fifo_sync_2ff.sv
// Two-flop synchronizer for a gray-coded pointer entering the other side of the FIFO.
// Cleared by the reset of the receiving side.
module fifo_sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/asynchronous_fifo.sv
// Gray-pointer FIFO with show-ahead read and independent write/read resets on one clock.
// Define ASYNC_FIFO_SYNC_EN to route each gray pointer through a 2-flop synchronizer.
module asynchronous_fifo
    import asynchronous_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  w_rst,
    input  logic                  r_rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    ptr_t r_wbin;
    ptr_t r_wgray;
    logic r_full;
    ptr_t r_rbin;
    ptr_t r_rgray;
    logic r_empty;

    logic w_wr_acc;
    logic w_rd_acc;
    ptr_t w_wbin_next;
    ptr_t w_wgray_next;
    ptr_t w_rbin_next;
    ptr_t w_rgray_next;
    ptr_t w_wgray_seen;
    ptr_t w_rgray_seen;
    logic w_full_next;
    logic w_empty_next;

`ifdef ASYNC_FIFO_SYNC_EN
    fifo_sync_2ff #(.WIDTH($bits(ptr_t))) u_sync_w2r (
        .i_clk (clk),
        .i_rst (r_rst),
        .i_d   (r_wgray),
        .o_q   (w_wgray_seen)
    );

    fifo_sync_2ff #(.WIDTH($bits(ptr_t))) u_sync_r2w (
        .i_clk (clk),
        .i_rst (w_rst),
        .i_d   (r_rgray),
        .o_q   (w_rgray_seen)
    );
`else
    assign w_wgray_seen = r_wgray;
    assign w_rgray_seen = r_rgray;
`endif

    assign w_wr_acc     = w_en && !r_full;
    assign w_wbin_next  = r_wbin + ptr_t'(w_wr_acc);
    assign w_wgray_next = bin2gray(w_wbin_next);
    assign w_full_next  = (w_wgray_next == gray_lap_ahead(w_rgray_seen));

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wbin[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= w_full_next;
        end
    end

    assign w_rd_acc     = r_en && !r_empty;
    assign w_rbin_next  = r_rbin + ptr_t'(w_rd_acc);
    assign w_rgray_next = bin2gray(w_rbin_next);
    assign w_empty_next = (w_rgray_next == w_wgray_seen);

    always_ff @(posedge clk or posedge r_rst) begin
        if (r_rst) begin
            r_rbin  <= '0;
            r_rgray <= '0;
            r_empty <= 1'b1;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
            r_empty <= w_empty_next;
        end
    end

    assign data_out = r_empty ? '0 : r_mem[r_rbin[ADDR_WIDTH-1:0]];
    assign full     = r_full;
    assign empty    = r_empty;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Randomised bench for asynchronous_fifo against a count-history reference model.
module tb_asynchronous_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef ASYNC_FIFO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          w_rst;
    logic          r_rst;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    asynchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .w_rst    (w_rst),
        .r_rst    (r_rst),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: queue of stored words plus cumulative write/read counts per edge.
    // Index 0 is the count after the latest edge, index n the count n edges earlier.
    logic [DW-1:0] q[$];
    int            wr_h[4];
    int            rd_h[4];
    bit            m_empty;
    bit            m_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            wr_h[i] = 0;
            rd_h[i] = 0;
        end
        m_empty = 1'b1;
        m_full  = 1'b0;
    endtask

    // Called just after a negedge: drive, take one posedge, check at the next negedge.
    task automatic cycle(input bit we, input bit re, input logic [DW-1:0] d);
        bit            wacc;
        bit            racc;
        logic [DW-1:0] exp_dout;
        w_en    = we;
        r_en    = re;
        data_in = d;
        wacc = we && !m_full;
        racc = re && !m_empty;
        @(posedge clk);
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back(d);
        for (int i = 3; i > 0; i--) begin
            wr_h[i] = wr_h[i-1];
            rd_h[i] = rd_h[i-1];
        end
        wr_h[0] += int'(wacc);
        rd_h[0] += int'(racc);
        m_empty = (rd_h[0] == wr_h[LAT]);
        m_full  = ((wr_h[0] - rd_h[LAT]) == DEPTH);
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        exp_dout = '0;
        if (!m_empty) exp_dout = q[0];
        chk("empty", 32'(empty), 32'(m_empty));
        chk("full", 32'(full), 32'(m_full));
        chk("data_out", 32'(data_out), 32'(exp_dout));
    endtask

    task automatic do_reset();
        @(negedge clk);
        w_rst = 1'b1;
        r_rst = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        repeat (10) @(negedge clk);
        w_rst = 1'b0;
        r_rst = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        repeat (LAT + 1) cycle(1'b0, 1'b0, '0);
    endtask

    initial begin
        int       n;
        int       pops;
        bit [7:0] rnd;

        w_rst   = 1'b1;
        r_rst   = 1'b1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        model_reset();

        // Reset state
        do_reset();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_dout", 32'(data_out), 32'd0);

        // Single word with show-ahead
        cycle(1'b1, 1'b0, 8'hA5);
        n = 0;
        while (empty && n < 10) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        chk("single_wait", 32'(n < 10), 32'd1);
        chk("single_showahead", 32'(data_out), 32'hA5);
        cycle(1'b0, 1'b1, '0);
        chk("single_pop_empty", 32'(empty), 32'd1);
        chk("single_pop_dout", 32'(data_out), 32'd0);

        // Fill to DEPTH, overflow attempt, ordered drain
        settle();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i));
        chk("fill_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, 8'hFF);
        chk("fill_still_full", 32'(full), 32'd1);
        settle();
        pops = 0;
        while (!empty && pops < 2 * DEPTH) begin
            chk("fill_order", 32'(data_out), 32'(pops));
            cycle(1'b0, 1'b1, '0);
            pops++;
        end
        chk("fill_pop_count", 32'(pops), 32'(DEPTH));
        chk("fill_drained", 32'(empty), 32'd1);

        // Wrap: two passes, write and read on even cycles
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 30; c++) begin
                rnd = 8'($urandom);
                if (c % 2 == 0) cycle(1'b1, !empty, rnd);
                else            cycle(1'b0, 1'b0, '0);
            end
        end
        settle();
        while (!empty && q.size() > 0) cycle(1'b0, 1'b1, '0);
        chk("wrap_drained", 32'(empty), 32'd1);

        // Simultaneous read/write with 4 words held
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom));
        settle();
        for (int c = 0; c < 20; c++) cycle(1'b1, 1'b1, 8'($urandom));
        settle();
        pops = 0;
        while (!empty && pops < 2 * DEPTH) begin
            cycle(1'b0, 1'b1, '0);
            pops++;
        end
        chk("simul_occupancy", 32'(pops), 32'd4);

        // Simultaneous read/write while full: write dropped, read succeeds
        settle();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'($urandom));
        chk("simul_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 8'hEE);
        settle();
        pops = 0;
        while (!empty && pops < 2 * DEPTH) begin
            cycle(1'b0, 1'b1, '0);
            pops++;
        end
        chk("full_rw_count", 32'(pops), 32'(DEPTH - 1));

        // Underflow: pop while empty changes nothing
        settle();
        cycle(1'b0, 1'b1, '0);
        chk("underflow_empty", 32'(empty), 32'd1);
        chk("underflow_dout", 32'(data_out), 32'd0);

        // Mid-stream reset acts without a clock edge
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'($urandom));
        settle();
        chk("mid_pre_empty", 32'(empty), 32'd0);
        #2;
        w_rst = 1'b1;
        r_rst = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_dout", 32'(data_out), 32'd0);
        repeat (3) @(negedge clk);
        w_rst = 1'b0;
        r_rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 8'h3C);
        settle();
        chk("post_rst_dout", 32'(data_out), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
